// File: rtl/decode.sv
// Decode stage: register file with PC read at index 15, immediate extension and D/E pipeline
// register. Define DECODE_BYPASS_EN to let a same-cycle writeback pass straight to the read ports.
`timescale 1ns/1ps
module decode #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] InstrD,
  input  logic [N-1:0] PCPlus8D,
  input  logic [1:0]   RegSrcD,
  input  logic [1:0]   ImmSrcD,
  input  logic         RegWriteW,
  input  logic [3:0]   WA3W,
  input  logic [N-1:0] ResultW,
  input  logic         StallE,
  input  logic         FlushE,
  output logic [N-1:0] RD1E,
  output logic [N-1:0] RD2E,
  output logic [N-1:0] ExtImmE,
  output logic [3:0]   RA1E,
  output logic [3:0]   RA2E,
  output logic [3:0]   WA3E
);

  localparam logic [3:0] PcIdx = 4'd15;

  logic [N-1:0] rf_q [15];
  logic [3:0]   ra1_d, ra2_d, wa3_d;
  logic [N-1:0] rd1_d, rd2_d, ext_d;
  logic         wb_en;

  assign ra1_d = RegSrcD[0] ? PcIdx : InstrD[19:16];
  assign ra2_d = RegSrcD[1] ? InstrD[15:12] : InstrD[3:0];
  assign wa3_d = InstrD[15:12];
  assign wb_en = RegWriteW && (WA3W != PcIdx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 15; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (wb_en && (WA3W == 4'(i))) rf_q[i] <= ResultW;
      end
    end
  end

  // Index 15 is not storage: it always reads the fetch-supplied PC+8.
  function automatic logic [N-1:0] read_port(input logic [3:0] ra);
    logic [N-1:0] val;
    val = PCPlus8D;
    for (int i = 0; i < 15; i++) begin
      if (ra == 4'(i)) val = rf_q[i];
    end
`ifdef DECODE_BYPASS_EN
    if (wb_en && (WA3W == ra)) val = ResultW;
`endif
    return val;
  endfunction

  always_comb begin
    rd1_d = read_port(ra1_d);
    rd2_d = read_port(ra2_d);
  end

  always_comb begin
    ext_d = '0;
    case (ImmSrcD)
      2'b00:   ext_d = N'(InstrD[7:0]);
      2'b01:   ext_d = N'(InstrD[11:0]);
      2'b10:   ext_d = {{(N-26){InstrD[23]}}, InstrD[23:0], 2'b00};
      default: ext_d = '0;
    endcase
  end

  // Flush wins over stall so a bubble can be inserted into a held stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RD1E    <= '0;
      RD2E    <= '0;
      ExtImmE <= '0;
      RA1E    <= '0;
      RA2E    <= '0;
      WA3E    <= '0;
    end else if (FlushE) begin
      RD1E    <= '0;
      RD2E    <= '0;
      ExtImmE <= '0;
      RA1E    <= '0;
      RA2E    <= '0;
      WA3E    <= '0;
    end else if (!StallE) begin
      RD1E    <= rd1_d;
      RD2E    <= rd2_d;
      ExtImmE <= ext_d;
      RA1E    <= ra1_d;
      RA2E    <= ra2_d;
      WA3E    <= wa3_d;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: expected E-stage values are queued when a step is driven and
// checked one edge later; covers reset, register read/write, PC read, immediates, stall/flush.
`timescale 1ns/1ps
module tb_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] InstrD = '0, PCPlus8D = '0, ResultW = '0;
  logic [1:0]  RegSrcD = '0, ImmSrcD = '0;
  logic        RegWriteW = 1'b0, StallE = 1'b0, FlushE = 1'b0;
  logic [3:0]  WA3W = '0;
  logic [31:0] RD1E, RD2E, ExtImmE;
  logic [3:0]  RA1E, RA2E, WA3E;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa3;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  decode #(.N(32)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCPlus8D(PCPlus8D), .RegSrcD(RegSrcD),
    .ImmSrcD(ImmSrcD), .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW),
    .StallE(StallE), .FlushE(FlushE), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] ext, input logic [3:0] ra1,
                              input logic [3:0] ra2, input logic [3:0] wa3);
    exp_t e;
    e.rd1 = rd1; e.rd2 = rd2; e.ext = ext; e.ra1 = ra1; e.ra2 = ra2; e.wa3 = wa3;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".RD1E"}, RD1E, e.rd1);
    chk({tag, ".RD2E"}, RD2E, e.rd2);
    chk({tag, ".ExtImmE"}, ExtImmE, e.ext);
    chk({tag, ".RA1E"}, 32'(RA1E), 32'(e.ra1));
    chk({tag, ".RA2E"}, 32'(RA2E), 32'(e.ra2));
    chk({tag, ".WA3E"}, 32'(WA3E), 32'(e.wa3));
  endtask

  task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] pc8,
                      input logic [1:0] rsrc, input logic [1:0] isrc, input logic rw,
                      input logic [3:0] wa, input logic [31:0] res, input logic st,
                      input logic fl, input exp_t e);
    @(negedge clk);
    InstrD = instr; PCPlus8D = pc8; RegSrcD = rsrc; ImmSrcD = isrc;
    RegWriteW = rw; WA3W = wa; ResultW = res; StallE = st; FlushE = fl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  exp_t e_i;
  logic [31:0] byp_exp;

  initial begin
    #12;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    pop_check("reset_state");
    @(negedge clk);
    rst = 1'b1;

    step("wr_r5",   32'h0, 32'h0, 2'b00, 2'b11, 1, 4'd5, 32'hDEADBEEF, 0, 0, mk(0, 0, 0, 0, 0, 0));
    step("rd_r5",   32'h00050000, 32'h0, 2'b00, 2'b11, 0, 4'd0, 32'h0, 0, 0,
         mk(32'hDEADBEEF, 0, 0, 4'd5, 4'd0, 4'd0));
    step("wr_r3",   32'h0, 32'h0, 2'b00, 2'b11, 1, 4'd3, 32'h55, 0, 0, mk(0, 0, 0, 0, 0, 0));
    step("pc_rd",   32'h00003003, 32'h108, 2'b01, 2'b00, 1, 4'd15, 32'h1, 0, 0,
         mk(32'h108, 32'h55, 32'h03, 4'd15, 4'd3, 4'd3));
    step("pc_rd2",  32'h00003003, 32'h108, 2'b01, 2'b00, 0, 4'd0, 32'h0, 0, 0,
         mk(32'h108, 32'h55, 32'h03, 4'd15, 4'd3, 4'd3));
    step("imm_br",  32'h00FFFFFF, 32'h200, 2'b00, 2'b10, 0, 4'd0, 32'h0, 0, 0,
         mk(32'h200, 32'h200, 32'hFFFFFFFC, 4'd15, 4'd15, 4'd15));
    step("imm_12",  32'h00FFFFFF, 32'h200, 2'b00, 2'b01, 0, 4'd0, 32'h0, 0, 0,
         mk(32'h200, 32'h200, 32'h00000FFF, 4'd15, 4'd15, 4'd15));
    step("imm_8",   32'h00FFFFFF, 32'h200, 2'b00, 2'b00, 1, 4'd2, 32'h77, 0, 0,
         mk(32'h200, 32'h200, 32'h000000FF, 4'd15, 4'd15, 4'd15));
    e_i = mk(32'hDEADBEEF, 32'h55, 32'h02, 4'd5, 4'd3, 4'd3);
    step("ra2_dst", 32'h00053002, 32'h0, 2'b10, 2'b00, 0, 4'd0, 32'h0, 0, 0, e_i);
    step("stall1",  32'h00010001, 32'h0, 2'b00, 2'b00, 1, 4'd1, 32'hAAAA, 1, 0, e_i);
    step("stall2",  32'h00010001, 32'h0, 2'b00, 2'b00, 0, 4'd0, 32'h0, 1, 0, e_i);
    step("rd_r1",   32'h00010000, 32'h0, 2'b00, 2'b11, 0, 4'd0, 32'h0, 0, 0,
         mk(32'hAAAA, 0, 0, 4'd1, 4'd0, 4'd0));
    step("flush",   32'h00053002, 32'h0, 2'b10, 2'b00, 0, 4'd0, 32'h0, 1, 1, mk(0, 0, 0, 0, 0, 0));
`ifdef DECODE_BYPASS_EN
    byp_exp = 32'h1234;
`else
    byp_exp = 32'h77;
`endif
    step("bypass",  32'h00020000, 32'h0, 2'b00, 2'b11, 1, 4'd2, 32'h1234, 0, 0,
         mk(byp_exp, 0, 0, 4'd2, 4'd0, 4'd0));
    step("rd_r2",   32'h00020000, 32'h0, 2'b00, 2'b11, 0, 4'd0, 32'h0, 0, 0,
         mk(32'h1234, 0, 0, 4'd2, 4'd0, 4'd0));

    // Reset mid-cycle with a writeback pending on the next edge.
    @(negedge clk);
    RegWriteW = 1'b1; WA3W = 4'd4; ResultW = 32'h99;
    #2 rst = 1'b0;
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    pop_check("async_rst");
    @(negedge clk);
    rst = 1'b1;
    RegWriteW = 1'b0;
    step("post_rst", 32'h00030004, 32'h0, 2'b00, 2'b11, 0, 4'd0, 32'h0, 0, 0,
         mk(0, 0, 0, 4'd3, 4'd4, 4'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
